// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue/writeback stage: op codes, status bit
// positions, instruction field layout and FSM state encoding.
package alu_pkg;

    localparam int NREGS_DEF = 8;
    localparam int DW_DEF    = 8;
    localparam int IW        = 16;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SBC = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;

    localparam int SREG_Z = 0;
    localparam int SREG_C = 1;
    localparam int SREG_N = 2;
    localparam int SREG_V = 3;

    localparam int F_OP_LO   = 12;
    localparam int F_RD_LO   = 9;
    localparam int F_IMM_SEL = 8;
    localparam int F_IMM_LO  = 0;
    localparam int F_RS_LO   = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_e;

    function automatic logic op_writes_reg(input logic [3:0] op);
        return (op inside {OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_OR, OP_AND});
    endfunction

    // NOP and the reserved codes leave the ALU status cleared.
    function automatic logic op_sets_flags(input logic [3:0] op);
        return (op inside {OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP, OP_OR, OP_AND});
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// General register file: one write port, three combinational read ports
// (destination operand, source operand, debug).
module alu_regfile #(
    parameter int NREGS = 8,
    parameter int DW    = 8,
    parameter int RW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr_rd,
    output logic [DW-1:0] rdata_rd,
    input  logic [RW-1:0] raddr_rs,
    output logic [DW-1:0] rdata_rs,
    input  logic [RW-1:0] raddr_dbg,
    output logic [DW-1:0] rdata_dbg
);

    logic [DW-1:0] mem_q [NREGS];
    logic [DW-1:0] mem_d [NREGS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_rd  = mem_q[raddr_rd];
    assign rdata_rs  = mem_q[raddr_rs];
    assign rdata_dbg = mem_q[raddr_dbg];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch, issue and writeback stage in front of the 8-bit ALU.
// IDLE accepts and registers operands, ISSUE lets the ALU settle, WB retires.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    input  logic [15:0]   instr,
    output logic          instr_ready,
    output logic [3:0]    alu_fn,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    input  logic [3:0]    alu_sreg,
    output logic [3:0]    flags,
    output logic          wb_valid,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int RW = $clog2(NREGS);

    state_e        state_q, state_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [3:0]    alu_fn_q, alu_fn_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [DW-1:0] res_q, res_d;
    logic [3:0]    sreg_q, sreg_d;
    logic [3:0]    flags_q, flags_d;
    logic          wb_valid_q, wb_valid_d;

    logic [DW-1:0] rd_data, rs_data;
    logic [3:0]    held_op;
    logic [RW-1:0] held_rd;
    logic          rf_we;

    assign held_op = instr_q[F_OP_LO +: 4];
    assign held_rd = instr_q[F_RD_LO +: RW];
    assign rf_we   = (state_q == S_WB) && op_writes_reg(held_op);

    // Writes land at the edge that re-enters IDLE, so a following accept
    // reads the post-write file without any bypass.
    alu_regfile #(.NREGS(NREGS), .DW(DW)) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we        (rf_we),
        .waddr     (held_rd),
        .wdata     (res_q),
        .raddr_rd  (instr[F_RD_LO +: RW]),
        .rdata_rd  (rd_data),
        .raddr_rs  (instr[F_RS_LO +: RW]),
        .rdata_rs  (rs_data),
        .raddr_dbg (dbg_addr[RW-1:0]),
        .rdata_dbg (dbg_data)
    );

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        alu_fn_d   = alu_fn_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        res_d      = res_q;
        sreg_d     = sreg_q;
        flags_d    = flags_q;
        wb_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                alu_fn_d = OP_NOP;
                if (instr_valid) begin
                    instr_d  = instr;
                    alu_fn_d = instr[F_OP_LO +: 4];
                    alu_a_d  = rd_data;
                    alu_b_d  = instr[F_IMM_SEL] ? instr[F_IMM_LO +: DW] : rs_data;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                res_d      = alu_result;
                sreg_d     = alu_sreg;
                alu_fn_d   = OP_NOP;
                wb_valid_d = 1'b1;
                state_d    = S_WB;
            end
            S_WB: begin
                flags_d = op_sets_flags(held_op) ? sreg_q : 4'b0000;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            alu_fn_q   <= OP_NOP;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            res_q      <= '0;
            sreg_q     <= '0;
            flags_q    <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            alu_fn_q   <= alu_fn_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            res_q      <= res_d;
            sreg_q     <= sreg_d;
            flags_q    <= flags_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign alu_fn      = alu_fn_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign flags       = flags_q;
    assign wb_valid    = wb_valid_q;

endmodule
